// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: run-control state encoding, step counter width and default timing parameters
package cpu_dbg_pkg;
  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    PAUSED     = 3'd1,
    STEP       = 3'd2,
    RUN_SLOW   = 3'd3,
    RUN_FAST   = 3'd4
  } run_state_t;
  localparam int STEP_W = 16;
  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int DEBOUNCE_DEF = 1_000_000;
  localparam int CPU_RST_DEF = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a raw button, emitting a one-cycle pulse on press
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, level_d, settle;
  logic [CW-1:0] cnt;
  assign settle = cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      level_d <= level;
      press <= level & ~level_d;
      cnt <= (s2 == level || settle) ? '0 : cnt + CW'(1);
      if (s2 != level && settle) level <= s2;
    end
  end
endmodule

// File: rtl/cpu_run_control.sv
// cpu_run_control: drives core reset/halt for timed reset, single-step, slow run and full-speed run
module cpu_run_control
  import cpu_dbg_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CPU_RST_CYCLES  = CPU_RST_DEF
) (
  input  logic              CK_REF,
  input  logic              RST_N,
  input  logic              BTN_STEP,
  input  logic              BTN_RUN,
  input  logic              SW_FAST,
  input  logic              SW_CPU_RST,
  output logic              CPU_RST_N,
  output logic              CPU_HALT,
  output logic              RUNNING,
  output logic [STEP_W-1:0] STEP_COUNT
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(CPU_RST_CYCLES + 1);
  run_state_t state, nxt;
  logic step_press, run_press, tick_end, hold_done, nxt_halt;
  logic [1:0] fast_s, rst_s;
  logic [TW-1:0] tick;
  logic [HW-1:0] hold;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(CK_REF), .rst_n(RST_N), .btn(BTN_STEP), .press(step_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(CK_REF), .rst_n(RST_N), .btn(BTN_RUN), .press(run_press)
  );
  assign tick_end = tick == TW'(TICK_DIV - 1);
  assign hold_done = hold == HW'(CPU_RST_CYCLES);
  always_comb begin
    nxt = state;
    if (rst_s[1]) nxt = RESET_HOLD;
    else begin
      case (state)
        RESET_HOLD: nxt = hold_done ? PAUSED : RESET_HOLD;
        PAUSED:     nxt = run_press ? (fast_s[1] ? RUN_FAST : RUN_SLOW) : step_press ? STEP : PAUSED;
        STEP:       nxt = PAUSED;
        RUN_SLOW:   nxt = run_press ? PAUSED : fast_s[1] ? RUN_FAST : RUN_SLOW;
        RUN_FAST:   nxt = run_press ? PAUSED : fast_s[1] ? RUN_FAST : RUN_SLOW;
        default:    nxt = RESET_HOLD;
      endcase
    end
    nxt_halt = !(nxt == STEP || nxt == RUN_FAST || (nxt == RUN_SLOW && state == RUN_SLOW && tick_end));
  end
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state <= RESET_HOLD;
      fast_s <= '0;
      rst_s <= '0;
      tick <= '0;
      hold <= '0;
      CPU_RST_N <= 1'b0;
      CPU_HALT <= 1'b1;
      RUNNING <= 1'b0;
      STEP_COUNT <= '0;
    end else begin
      state <= nxt;
      fast_s <= {fast_s[0], SW_FAST};
      rst_s <= {rst_s[0], SW_CPU_RST};
      tick <= (state == RUN_SLOW && nxt == RUN_SLOW && !tick_end) ? tick + TW'(1) : '0;
      hold <= (state == RESET_HOLD && nxt == RESET_HOLD && !rst_s[1]) ? hold + HW'(1) : '0;
      CPU_RST_N <= nxt != RESET_HOLD;
      CPU_HALT <= nxt_halt;
      RUNNING <= nxt == RUN_SLOW || nxt == RUN_FAST;
      STEP_COUNT <= nxt == RESET_HOLD ? '0 : STEP_COUNT + STEP_W'(!nxt_halt);
    end
  end
endmodule

// File: tb/tb_cpu_run_control.sv
// tb_cpu_run_control: directed bench with a release-cycle scoreboard for cpu_run_control
module tb_cpu_run_control;
  import cpu_dbg_pkg::*;
  logic CK_REF = 1'b0;
  logic RST_N = 1'b0;
  logic BTN_STEP = 1'b0;
  logic BTN_RUN = 1'b0;
  logic SW_FAST = 1'b0;
  logic SW_CPU_RST = 1'b0;
  logic CPU_RST_N, CPU_HALT, RUNNING;
  logic [STEP_W-1:0] STEP_COUNT;
  logic [18:0] outs;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mon_exp;
  bit mon_en = 1'b0;
  int rel_q[$];
  cpu_run_control #(.TICK_DIV(4), .DEBOUNCE_CYCLES(4), .CPU_RST_CYCLES(3)) dut (
    .CK_REF(CK_REF), .RST_N(RST_N), .BTN_STEP(BTN_STEP), .BTN_RUN(BTN_RUN),
    .SW_FAST(SW_FAST), .SW_CPU_RST(SW_CPU_RST), .CPU_RST_N(CPU_RST_N),
    .CPU_HALT(CPU_HALT), .RUNNING(RUNNING), .STEP_COUNT(STEP_COUNT)
  );
  assign outs = {CPU_RST_N, CPU_HALT, RUNNING, STEP_COUNT};
  always #5 CK_REF = ~CK_REF;
  function automatic logic [18:0] o(input logic r, input logic h, input logic ru, input logic [15:0] n);
    return {r, h, ru, n};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [18:0] exp);
    chk(tag, 32'(outs), 32'(exp));
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK_REF);
      #1;
    end
  endtask
  initial forever begin
    @(posedge CK_REF);
    cyc++;
    #2;
    if (mon_en && CPU_HALT === 1'b0) begin
      total++;
      mon_exp = rel_q.size() > 0 ? rel_q.pop_front() : -1;
      assert (cyc === mon_exp) else begin
        bad++;
        $error("FAIL release_cycle observed=%0d expected=%0d", cyc, mon_exp);
      end
    end
  end
  initial begin
    int c;
    step(3);
    chk_out("reset_outputs", o(0, 1, 0, 0));
    RST_N = 1'b1;
    step(3);
    chk("bringup_held", 32'(CPU_RST_N), 0);
    step(1);
    chk_out("bringup_paused", o(1, 1, 0, 0));
    mon_en = 1'b1;
    c = cyc;
    rel_q.push_back(c + 8);
    BTN_STEP = 1'b1;
    step(7);
    chk("step_not_early", 32'(CPU_HALT), 1);
    step(1);
    chk_out("step_release", o(1, 0, 0, 1));
    step(1);
    chk_out("step_one_cycle", o(1, 1, 0, 1));
    step(1);
    BTN_STEP = 1'b0;
    step(10);
    BTN_STEP = 1'b1;
    step(3);
    BTN_STEP = 1'b0;
    step(12);
    chk_out("glitch_ignored", o(1, 1, 0, 1));
    c = cyc;
    for (int k = 1; k <= 5; k++) rel_q.push_back(c + 8 + 4 * k);
    BTN_RUN = 1'b1;
    step(8);
    chk_out("slow_entry", o(1, 1, 1, 1));
    step(2);
    BTN_RUN = 1'b0;
    step(18);
    chk_out("slow_five_releases", o(1, 0, 1, 6));
    c = cyc;
    for (int k = 1; k <= 5; k++) rel_q.push_back(c + 4 * k);
    BTN_STEP = 1'b1;
    step(10);
    BTN_STEP = 1'b0;
    step(10);
    chk_out("slow_step_ignored", o(1, 0, 1, 11));
    c = cyc;
    rel_q.push_back(c + 4);
    BTN_RUN = 1'b1;
    step(8);
    chk_out("slow_pause", o(1, 1, 0, 12));
    step(2);
    BTN_RUN = 1'b0;
    step(10);
    mon_en = 1'b0;
    SW_FAST = 1'b1;
    BTN_RUN = 1'b1;
    step(8);
    chk_out("fast_entry", o(1, 0, 1, 13));
    step(2);
    BTN_RUN = 1'b0;
    step(10);
    chk_out("fast_continuous", o(1, 0, 1, 25));
    SW_FAST = 1'b0;
    step(3);
    chk_out("fast_to_slow", o(1, 1, 1, 27));
    mon_en = 1'b1;
    c = cyc;
    rel_q.push_back(c + 4);
    rel_q.push_back(c + 8);
    step(8);
    chk_out("slow_after_fast", o(1, 0, 1, 29));
    SW_FAST = 1'b1;
    step(1);
    mon_en = 1'b0;
    step(4);
    chk_out("fast_again", o(1, 0, 1, 32));
    SW_CPU_RST = 1'b1;
    BTN_RUN = 1'b1;
    step(2);
    chk("swrst_sync_delay", 32'(RUNNING), 1);
    step(1);
    chk_out("swrst_forced", o(0, 1, 0, 0));
    step(7);
    BTN_RUN = 1'b0;
    step(10);
    chk_out("swrst_hold", o(0, 1, 0, 0));
    SW_CPU_RST = 1'b0;
    step(5);
    chk("swrst_release_wait", 32'(CPU_RST_N), 0);
    step(1);
    chk_out("swrst_released", o(1, 1, 0, 0));
    step(10);
    chk_out("run_press_in_reset_ignored", o(1, 1, 0, 0));
    BTN_RUN = 1'b1;
    step(10);
    BTN_RUN = 1'b0;
    step(65532);
    chk_out("wrap_ffff", o(1, 0, 1, 16'hffff));
    step(1);
    chk_out("wrap_zero", o(1, 0, 1, 0));
    BTN_RUN = 1'b1;
    step(8);
    chk_out("wrap_pause", o(1, 1, 0, 7));
    step(2);
    BTN_RUN = 1'b0;
    step(10);
    SW_FAST = 1'b0;
    step(3);
    mon_en = 1'b1;
    c = cyc;
    rel_q.push_back(c + 12);
    rel_q.push_back(c + 16);
    BTN_RUN = 1'b1;
    BTN_STEP = 1'b1;
    step(8);
    chk_out("both_press_run_wins", o(1, 1, 1, 7));
    step(2);
    BTN_RUN = 1'b0;
    BTN_STEP = 1'b0;
    step(6);
    chk_out("both_press_slow", o(1, 0, 1, 9));
    step(1);
    chk("release_queue_drained", 32'(rel_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
